// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bus bundle: imem request/response, decode handshake and redirect.
// Handshake rule: a transfer happens on the rising edge where valid && ready are both high;
// the producer holds its payload stable while valid is high and unaccepted, except that the
// imem address follows a redirect because the memory samples it only on a transfer.
interface ifu_fetch_ctrl_if #(
  parameter int CPU_WIDTH  = 64,
  parameter int INST_WIDTH = 32
);
  logic                  o_imem_req_vld;
  logic                  i_imem_req_rdy;
  logic [CPU_WIDTH-1:0]  o_imem_addr;
  logic                  i_imem_rsp_vld;
  logic [INST_WIDTH-1:0] i_imem_rsp_data;
  logic                  i_imem_rsp_err;
  logic                  o_inst_vld;
  logic                  i_inst_rdy;
  logic [INST_WIDTH-1:0] o_inst;
  logic [CPU_WIDTH-1:0]  o_inst_pc;
  logic                  o_inst_err;
  logic                  i_redir_vld;
  logic [CPU_WIDTH-1:0]  i_redir_pc;

  modport master (
    output o_imem_req_vld, o_imem_addr, o_inst_vld, o_inst, o_inst_pc, o_inst_err,
    input  i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data, i_imem_rsp_err,
    input  i_inst_rdy, i_redir_vld, i_redir_pc
  );

  modport slave (
    input  o_imem_req_vld, o_imem_addr, o_inst_vld, o_inst, o_inst_pc, o_inst_err,
    output i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data, i_imem_rsp_err,
    output i_inst_rdy, i_redir_vld, i_redir_pc
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and
// buffers the returned instruction for decode, discarding fetches made stale by redirects.
module ifu_fetch_ctrl #(
  parameter int                   CPU_WIDTH  = 64,
  parameter int                   INST_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RST_PC     = 64'h0000_0000_8000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ifu_fetch_ctrl_if.master bus,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CPU_WIDTH-1:0]  pc_q, pc_d;
  logic                  inst_vld_q, inst_vld_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [CPU_WIDTH-1:0]  inst_pc_q, inst_pc_d;
  logic                  inst_err_q, inst_err_d;

  logic pc_misaligned;
  logic req_vld;
  logic req_fire;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign req_vld       = (state_q == ST_REQ) && !pc_misaligned;
  assign req_fire      = req_vld && bus.i_imem_req_rdy;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_vld_d = inst_vld_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (bus.i_redir_vld) begin
          // A request accepted in the same cycle still owes us a response; drain it.
          pc_d    = bus.i_redir_pc;
          state_d = req_fire ? ST_DROP : ST_REQ;
        end else if (req_fire) begin
          state_d = ST_WAIT;
        end else if (pc_misaligned) begin
          state_d    = ST_HOLD;
          inst_vld_d = 1'b1;
          inst_d     = '0;
          inst_pc_d  = pc_q;
          inst_err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.i_redir_vld) begin
          pc_d    = bus.i_redir_pc;
          state_d = bus.i_imem_rsp_vld ? ST_REQ : ST_DROP;
        end else if (bus.i_imem_rsp_vld) begin
          state_d    = ST_HOLD;
          inst_vld_d = 1'b1;
          inst_d     = bus.i_imem_rsp_data;
          inst_pc_d  = pc_q;
          inst_err_d = bus.i_imem_rsp_err;
          pc_d       = pc_q + CPU_WIDTH'(4);
        end
      end
      ST_DROP: begin
        if (bus.i_redir_vld) pc_d = bus.i_redir_pc;
        if (bus.i_imem_rsp_vld) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (bus.i_redir_vld) begin
          inst_vld_d = 1'b0;
          pc_d       = bus.i_redir_pc;
          state_d    = ST_REQ;
        end else if (bus.i_inst_rdy) begin
          inst_vld_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RST_PC;
      inst_vld_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_vld_q <= inst_vld_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

  assign bus.o_imem_req_vld = req_vld;
  assign bus.o_imem_addr    = pc_q;
  assign bus.o_inst_vld     = inst_vld_q;
  assign bus.o_inst         = inst_q;
  assign bus.o_inst_pc      = inst_pc_q;
  assign bus.o_inst_err     = inst_err_q;
  assign o_dbg_state        = state_q;

endmodule
